// File: rtl/border_zone_averager.sv
// Border-strip zone averager: accumulates R/G/B per zone of the top or bottom strip over a frame,
// snapshots the sums at the frame edge and streams per-zone averages over valid/ready.
module border_zone_averager #(
  parameter int PIX_W       = 8,
  parameter int H_ACTIVE    = 1920,
  parameter int V_ACTIVE    = 1080,
  parameter int ZONE_W      = 128,
  parameter int BORDER_ROWS = 64,
  parameter int VS_POL      = 1,
  localparam int NZONES     = H_ACTIVE / ZONE_W,
  localparam int ZI_W       = (NZONES > 1) ? $clog2(NZONES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] red,
  input  logic [PIX_W-1:0] green,
  input  logic [PIX_W-1:0] blue,
  input  logic             de,
  input  logic             vsync,
  input  logic             edge_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ZI_W-1:0]  out_zone,
  output logic             out_last,
  output logic [PIX_W-1:0] avg_red,
  output logic [PIX_W-1:0] avg_green,
  output logic [PIX_W-1:0] avg_blue,
  output logic             frame_drop
);
  localparam int SH    = $clog2(ZONE_W * BORDER_ROWS);
  localparam int ACC_W = PIX_W + SH;
  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_LIM  = COL_W'(NZONES * ZONE_W);
  localparam logic [COL_W-1:0] ZW_C     = COL_W'(ZONE_W);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_BOT  = ROW_W'(V_ACTIVE - BORDER_ROWS);
  localparam logic [ROW_W-1:0] ROW_TOP  = ROW_W'(BORDER_ROWS);
  localparam logic [ZI_W-1:0]  LAST_IDX = ZI_W'(NZONES - 1);
  localparam logic             VS_ACT   = (VS_POL != 0);

  // Handshake: a beat transfers on a cycle where out_valid & out_ready; while out_valid is high
  // and out_ready low, zone index and averages hold, and out_valid only drops after a transfer.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               vs_q, de_q, es_q, es_d, drop_q, drop_d;
  logic [COL_W-1:0]   col_q, col_d, zone_sel;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ZI_W-1:0]    rd_idx_q, rd_idx_d;
  logic [ACC_W-1:0]   acc_q [NZONES][3];
  logic [ACC_W-1:0]   acc_d [NZONES][3];
  logic [ACC_W-1:0]   sh_q  [NZONES][3];
  logic [ACC_W-1:0]   sh_d  [NZONES][3];
  logic               frame_edge, de_fall, in_strip, pix_hit, xfer;

  always_comb begin
    frame_edge = (vsync == VS_ACT) && (vs_q != VS_ACT);
    de_fall    = de_q && !de;
    in_strip   = es_q ? (row_q >= ROW_BOT && row_q < ROW_MAX) : (row_q < ROW_TOP);
    zone_sel   = col_q / ZW_C;
    pix_hit    = de && in_strip && (col_q < COL_LIM);
    xfer       = (state_q == SEND) && out_ready;

    col_d = col_q;
    if (de_fall) col_d = '0;
    else if (de && col_q != COL_MAX) col_d = col_q + COL_W'(1);

    row_d = row_q;
    if (frame_edge) row_d = '0;
    else if (de_fall && row_q != ROW_MAX) row_d = row_q + ROW_W'(1);

    es_d = frame_edge ? edge_sel : es_q;

    // A pixel landing on the frame-edge cycle belongs to neither frame and is dropped.
    acc_d = acc_q;
    for (int z = 0; z < NZONES; z++) begin
      if (frame_edge) begin
        for (int c = 0; c < 3; c++) acc_d[z][c] = '0;
      end else if (pix_hit && zone_sel == COL_W'(z)) begin
        acc_d[z][0] = acc_q[z][0] + ACC_W'(red);
        acc_d[z][1] = acc_q[z][1] + ACC_W'(green);
        acc_d[z][2] = acc_q[z][2] + ACC_W'(blue);
      end
    end

    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    sh_d     = sh_q;
    drop_d   = 1'b0;
    if (state_q == IDLE) begin
      if (frame_edge) begin
        sh_d    = acc_q;
        state_d = SEND;
      end
    end else begin
      drop_d = frame_edge;
      if (xfer) begin
        if (rd_idx_q == LAST_IDX) begin
          state_d  = IDLE;
          rd_idx_d = '0;
        end else begin
          rd_idx_d = rd_idx_q + ZI_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vs_q     <= 1'b0;
      de_q     <= 1'b0;
      es_q     <= 1'b0;
      drop_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      rd_idx_q <= '0;
      for (int z = 0; z < NZONES; z++) begin
        for (int c = 0; c < 3; c++) begin
          acc_q[z][c] <= '0;
          sh_q[z][c]  <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      vs_q     <= vsync;
      de_q     <= de;
      es_q     <= es_d;
      drop_q   <= drop_d;
      col_q    <= col_d;
      row_q    <= row_d;
      rd_idx_q <= rd_idx_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
    end
  end

  // Truncating mean: the zone area is a power of two, so the divide is a slice.
  always_comb begin
    out_valid  = (state_q == SEND);
    out_zone   = out_valid ? rd_idx_q : '0;
    out_last   = out_valid && (rd_idx_q == LAST_IDX);
    avg_red    = out_valid ? sh_q[rd_idx_q][0][ACC_W-1:SH] : '0;
    avg_green  = out_valid ? sh_q[rd_idx_q][1][ACC_W-1:SH] : '0;
    avg_blue   = out_valid ? sh_q[rd_idx_q][2][ACC_W-1:SH] : '0;
    frame_drop = drop_q;
  end

endmodule

// File: tb/tb_border_zone_averager.sv
// Randomized bench for border_zone_averager: frame-level model of zone sums feeding an expected beat queue.
module tb_border_zone_averager;
  localparam int PW = 8, H = 16, V = 8, ZW = 4, BR = 2, NZ = 4, SHF = 3;
  localparam int BW = 2 + 1 + 3 * PW;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [PW-1:0] red = '0, green = '0, blue = '0;
  logic de = 1'b0, vsync = 1'b0, edge_sel = 1'b0, out_ready = 1'b0;
  logic out_valid, out_last, frame_drop;
  logic [1:0] out_zone;
  logic [PW-1:0] avg_red, avg_green, avg_blue;

  always #5 clk = ~clk;

  border_zone_averager #(.PIX_W(PW), .H_ACTIVE(H), .V_ACTIVE(V), .ZONE_W(ZW),
                         .BORDER_ROWS(BR), .VS_POL(1)) dut (
    .clk(clk), .rst_n(rst_n), .red(red), .green(green), .blue(blue), .de(de),
    .vsync(vsync), .edge_sel(edge_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_zone(out_zone), .out_last(out_last), .avg_red(avg_red), .avg_green(avg_green),
    .avg_blue(avg_blue), .frame_drop(frame_drop));

  int checks = 0, errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] hist_q[$];
  logic [7:0] pr [V][H];
  logic [7:0] pg [V][H];
  logic [7:0] pb [V][H];
  int ps [NZ][3];
  logic cur_es = 1'b0;
  int rmode = 0;
  logic vs_prev = 1'b0, exp_drop = 1'b0, exp_valid, is_edge;
  logic [BW-1:0] got;
  int drops = 0, dut_xfers = 0, mdl_pops = 0;

  // ---------------- stimulus helpers ----------------
  function automatic logic rdy(input int k);
    case (rmode)
      1:       return $urandom_range(0, 3) != 0;
      2:       return !(k >= 2 && k <= 6);
      3:       return 1'b0;
      4:       return k == 1;
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick(input logic v, input logic d, input logic [7:0] r, g, b, input int k);
    @(posedge clk); #1;
    vsync = v; de = d; red = r; green = g; blue = b;
    edge_sel = cur_es; out_ready = rdy(k);
  endtask

  // kind: 0 uniform 0x80, 1 per-zone red ramp in top rows, 2 truncation pattern, 3 random
  task automatic fill(input int kind);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        case (kind)
          0: begin pr[r][c] = 8'h80; pg[r][c] = 8'h80; pb[r][c] = 8'h80; end
          1: begin
            if (r < BR) begin
              pr[r][c] = 8'(8'h10 * (c / ZW + 1)); pg[r][c] = 8'h00; pb[r][c] = 8'h00;
            end else if (r >= V - BR) begin
              pr[r][c] = 8'h00; pg[r][c] = 8'h00; pb[r][c] = 8'h00;
            end else begin
              pr[r][c] = 8'hFF; pg[r][c] = 8'hFF; pb[r][c] = 8'hFF;
            end
          end
          default: begin
            pr[r][c] = 8'($urandom_range(0, 255));
            pg[r][c] = 8'($urandom_range(0, 255));
            pb[r][c] = 8'($urandom_range(0, 255));
          end
        endcase
        if (kind == 2 && r < BR && c < ZW) begin
          pr[r][c] = (r == 1 && c == 3) ? 8'h00 : 8'hFF;
          pg[r][c] = pr[r][c]; pb[r][c] = pr[r][c];
        end
      end
  endtask

  task automatic drive_frame(input logic es, input int kind, input int mode);
    int k;
    k = 0; cur_es = es; rmode = mode;
    fill(kind);
    tick(1, 0, 0, 0, 0, k); k++;
    tick(1, 0, 0, 0, 0, k); k++;
    tick(0, 0, 0, 0, 0, k); k++;
    tick(0, 0, 0, 0, 0, k); k++;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        tick(0, 1, pr[r][c], pg[r][c], pb[r][c], k); k++;
      end
      for (int j = 0; j < 3; j++) begin
        tick(0, 0, 0, 0, 0, k); k++;
      end
    end
    // sums of this frame's strip, consumed by the next frame edge
    for (int z = 0; z < NZ; z++) begin
      ps[z][0] = 0; ps[z][1] = 0; ps[z][2] = 0;
      for (int r = 0; r < V; r++)
        if (es ? (r >= V - BR) : (r < BR))
          for (int c = z * ZW; c < (z + 1) * ZW; c++) begin
            ps[z][0] += pr[r][c]; ps[z][1] += pg[r][c]; ps[z][2] += pb[r][c];
          end
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input int z);
    return {2'(z), (z == NZ - 1), 8'(ps[z][0] >> SHF), 8'(ps[z][1] >> SHF), 8'(ps[z][2] >> SHF)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, req);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if ({out_valid, out_zone, out_last, avg_red, avg_green, avg_blue, frame_drop} !== '0) begin
        errors++;
        $display("FAIL reset_outputs valid=%0b zone=%0d last=%0b r=%0h g=%0h b=%0h drop=%0b required all 0",
                 out_valid, out_zone, out_last, avg_red, avg_green, avg_blue, frame_drop);
      end
      exp_q.delete(); vs_prev = 1'b0; exp_drop = 1'b0;
    end else begin
      exp_valid = exp_q.size() > 0;
      checks++;
      if (out_valid !== exp_valid) begin
        errors++;
        $display("FAIL out_valid got %0b expected %0b at %0t", out_valid, exp_valid, $time);
      end
      checks++;
      if (frame_drop !== exp_drop) begin
        errors++;
        $display("FAIL frame_drop got %0b expected %0b at %0t", frame_drop, exp_drop, $time);
      end
      if (exp_valid && out_valid) begin
        got = {out_zone, out_last, avg_red, avg_green, avg_blue};
        checks++;
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL beat got %h expected %h at %0t", got, exp_q[0], $time);
        end
      end
      if (out_valid && out_ready) dut_xfers++;
      is_edge = vsync && !vs_prev;
      vs_prev = vsync;
      exp_drop = 1'b0;
      if (is_edge) begin
        if (exp_valid) begin
          exp_drop = 1'b1; drops++;
        end else begin
          for (int z = 0; z < NZ; z++) begin
            exp_q.push_back(mk_beat(z));
            hist_q.push_back(mk_beat(z));
          end
        end
      end
      if (exp_valid && out_ready) begin
        void'(exp_q.pop_front());
        mdl_pops++;
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int z = 0; z < NZ; z++) begin ps[z][0] = 0; ps[z][1] = 0; ps[z][2] = 0; end
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    drive_frame(0, 0, 0);   // uniform grey
    drive_frame(0, 1, 0);   // red ramp, top strip
    drive_frame(1, 1, 0);   // same frame, bottom strip
    drive_frame(1, 2, 0);   // truncation pattern (read as top below)
    drive_frame(0, 2, 2);   // truncation frame read out with a 5-cycle stall on zone 1
    drive_frame(0, 3, 3);   // readout held off for the whole frame
    drive_frame($urandom_range(0, 1) != 0, 3, 1);  // edge while sending -> drop
    drive_frame(0, 3, 4);   // one beat accepted, then stalled

    @(posedge clk); #1;
    rst_n = 1'b0; out_ready = 1'b0; de = 1'b0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int z = 0; z < NZ; z++) begin ps[z][0] = 0; ps[z][1] = 0; ps[z][2] = 0; end

    drive_frame(0, 3, 0);
    drive_frame($urandom_range(0, 1) != 0, 3, 1);

    rmode = 0;
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      if (exp_q.size() == 0) break;
    end
    repeat (3) tick(0, 0, 0, 0, 0, 0);

    chk("xfer_count", 32'(dut_xfers), 32'(mdl_pops));
    chk("hist_size", 32'(hist_q.size()), 32'd40);
    chk("drop_count", 32'(drops), 32'd1);
    if (hist_q.size() >= 20) begin
      for (int z = 0; z < NZ; z++) begin
        chk("uniform_beat", 32'(hist_q[4 + z]), 32'({2'(z), z == 3, 8'h80, 8'h80, 8'h80}));
        chk("ramp_top_beat", 32'(hist_q[8 + z]), 32'({2'(z), z == 3, 8'(8'h10 * (z + 1)), 8'h00, 8'h00}));
        chk("ramp_bottom_beat", 32'(hist_q[12 + z]), 32'({2'(z), z == 3, 8'h00, 8'h00, 8'h00}));
      end
      chk("trunc_zone0", 32'(hist_q[20]), 32'({2'd0, 1'b0, 8'hDF, 8'hDF, 8'hDF}));
    end else begin
      errors++;
      $display("FAIL hist_short got %0d beats required at least 20", hist_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
